// File: rtl/ctr_drbg_generate.sv
// CTR_DRBG generate (AES-256, 128-bit V, no derivation function): streams NUM
// output blocks through a shared AES core, then runs Update and returns new state.
module ctr_drbg_generate #(
    parameter logic [31:0] RESEED_INTERVAL = 32'd1048576,
    parameter logic [15:0] MAX_BLOCKS      = 16'd4096
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [255:0] key_in,
    input  logic [127:0] v_in,
    input  logic [31:0]  reseed_counter_in,
    input  logic [383:0] additional_input,
    input  logic [15:0]  num_blocks,
    output logic         aes_start,
    output logic [255:0] aes_key,
    output logic [127:0] aes_pt,
    input  logic         aes_done,
    input  logic [127:0] aes_ct,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_last,
    output logic         done,
    output logic [1:0]   status,
    output logic [255:0] new_key,
    output logic [127:0] new_V,
    output logic [31:0]  new_reseed_counter
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ERR,
        S_UPD_START,
        S_UPD_WAIT,
        S_UPD_MIX,
        S_GEN_START,
        S_GEN_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t        state;
    logic [255:0]  key_r;
    logic [127:0]  v_r;
    logic [31:0]   ctr_r;
    logic [383:0]  ai_r;
    logic [383:0]  temp;
    logic [15:0]   remaining;
    logic [1:0]    iter;
    logic          fin;     // update in progress is the final one (after the blocks)

    logic [383:0]  mixed;
    logic [127:0]  v_next;

    assign mixed  = temp ^ ai_r;
    assign v_next = v_r + 128'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            req_ready          <= 1'b1;
            key_r              <= '0;
            v_r                <= '0;
            ctr_r              <= '0;
            ai_r               <= '0;
            temp               <= '0;
            remaining          <= '0;
            iter               <= '0;
            fin                <= 1'b0;
            aes_start          <= 1'b0;
            aes_key            <= '0;
            aes_pt             <= '0;
            out_valid          <= 1'b0;
            out_data           <= '0;
            out_last           <= 1'b0;
            done               <= 1'b0;
            status             <= '0;
            new_key            <= '0;
            new_V              <= '0;
            new_reseed_counter <= '0;
        end else begin
            aes_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        key_r     <= key_in;
                        v_r       <= v_in;
                        ctr_r     <= reseed_counter_in;
                        ai_r      <= additional_input;
                        remaining <= num_blocks;
                        iter      <= '0;
                        fin       <= 1'b0;
                        if (reseed_counter_in > RESEED_INTERVAL) begin
                            status <= 2'd1;
                            done   <= 1'b1;
                            state  <= S_ERR;
                        end else if (num_blocks == 16'd0 || num_blocks > MAX_BLOCKS) begin
                            status <= 2'd2;
                            done   <= 1'b1;
                            state  <= S_ERR;
                        end else if (additional_input != '0) begin
                            state <= S_UPD_START;
                        end else begin
                            state <= S_GEN_START;
                        end
                    end
                end
                S_ERR: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                S_UPD_START: begin
                    v_r       <= v_next;
                    aes_pt    <= v_next;
                    aes_key   <= key_r;
                    aes_start <= 1'b1;
                    state     <= S_UPD_WAIT;
                end
                S_UPD_WAIT: begin
                    if (aes_done) begin
                        // ciphertexts fill temp from the most significant slot down
                        case (iter)
                            2'd0:    temp[383:256] <= aes_ct;
                            2'd1:    temp[255:128] <= aes_ct;
                            default: temp[127:0]   <= aes_ct;
                        endcase
                        iter  <= iter + 2'd1;
                        state <= (iter == 2'd2) ? S_UPD_MIX : S_UPD_START;
                    end
                end
                S_UPD_MIX: begin
                    key_r <= mixed[383:128];
                    v_r   <= mixed[127:0];
                    iter  <= '0;
                    if (fin) begin
                        new_key            <= mixed[383:128];
                        new_V              <= mixed[127:0];
                        new_reseed_counter <= ctr_r + 32'd1;
                        status             <= 2'd0;
                        done               <= 1'b1;
                        state              <= S_DONE;
                    end else begin
                        state <= S_GEN_START;
                    end
                end
                S_GEN_START: begin
                    v_r       <= v_next;
                    aes_pt    <= v_next;
                    aes_key   <= key_r;
                    aes_start <= 1'b1;
                    state     <= S_GEN_WAIT;
                end
                S_GEN_WAIT: begin
                    if (aes_done) begin
                        out_data  <= aes_ct;
                        out_valid <= 1'b1;
                        out_last  <= (remaining == 16'd1);
                        state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    // next AES start waits for acceptance: single-block buffering only
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        remaining <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            fin   <= 1'b1;
                            iter  <= '0;
                            state <= S_UPD_START;
                        end else begin
                            state <= S_GEN_START;
                        end
                    end
                end
                S_DONE: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ctr_drbg_generate.sv
// Directed bench for ctr_drbg_generate with a toy keyed-permutation AES stand-in.
module tb_ctr_drbg_generate;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [255:0] key_in;
    logic [127:0] v_in;
    logic [31:0]  reseed_counter_in;
    logic [383:0] additional_input;
    logic [15:0]  num_blocks;
    logic         aes_start;
    logic [255:0] aes_key;
    logic [127:0] aes_pt;
    logic         aes_done;
    logic [127:0] aes_ct;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         out_last;
    logic         done;
    logic [1:0]   status;
    logic [255:0] new_key;
    logic [127:0] new_V;
    logic [31:0]  new_reseed_counter;

    ctr_drbg_generate dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .key_in(key_in), .v_in(v_in), .reseed_counter_in(reseed_counter_in),
        .additional_input(additional_input), .num_blocks(num_blocks),
        .aes_start(aes_start), .aes_key(aes_key), .aes_pt(aes_pt),
        .aes_done(aes_done), .aes_ct(aes_ct), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .status(status), .new_key(new_key), .new_V(new_V),
        .new_reseed_counter(new_reseed_counter)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [383:0] got, input logic [383:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] aes_f(input logic [255:0] k, input logic [127:0] p);
        return {p[63:0], p[127:64]} ^ k[255:128] ^ {k[63:0], k[127:64]}
               ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    endfunction

    // AES responder: latency lat cycles from the start pulse
    int           lat = 3;
    int           pend = 0;
    int           n_starts = 0;
    logic [255:0] lk;
    logic [127:0] lp;
    logic [127:0] q_pt[$];

    always @(negedge clk) begin
        aes_done = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                aes_done = 1'b1;
                aes_ct   = aes_f(lk, lp);
            end
        end
        if (aes_start) begin
            n_starts++;
            q_pt.push_back(aes_pt);
            lk   = aes_key;
            lp   = aes_pt;
            pend = lat;
        end
    end

    logic [127:0] q_dat[$];
    logic         q_last[$];
    logic         got_done;
    logic [1:0]   got_st;
    int           got_cyc;
    int           stable_err;
    int           stall_starts;

    function automatic logic [127:0] pt_at(input int i);
        return (i < q_pt.size()) ? q_pt[i] : 128'hDEAD;
    endfunction
    function automatic logic [127:0] dat_at(input int i);
        return (i < q_dat.size()) ? q_dat[i] : 128'hDEAD;
    endfunction
    function automatic logic last_at(input int i);
        return (i < q_last.size()) ? q_last[i] : 1'bx;
    endfunction

    task automatic run(input logic [255:0] k, input logic [127:0] v, input logic [31:0] ctr,
                       input logic [383:0] ai, input logic [15:0] nb, input int stall);
        logic [127:0] held;
        int sc;
        held = '0;
        sc = 0;
        q_pt.delete(); q_dat.delete(); q_last.delete();
        n_starts = 0; stable_err = 0; stall_starts = 0; got_done = 1'b0; got_st = 2'd3; got_cyc = -1;
        out_ready = (stall == 0);
        @(negedge clk);
        key_in = k; v_in = v; reseed_counter_in = ctr; additional_input = ai; num_blocks = nb;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1; got_st = status; got_cyc = cyc;
                break;
            end
            if (out_valid && !out_ready && aes_start) stall_starts++;
            if (out_valid) begin
                if (sc < stall) begin
                    if (sc > 0 && out_data !== held) stable_err++;
                    held = out_data; out_ready = 1'b0; sc++;
                end else begin
                    if (stall > 0 && out_data !== held) stable_err++;
                    out_ready = 1'b1;
                    q_dat.push_back(out_data);
                    q_last.push_back(out_last);
                    sc = 0;
                end
            end else if (stall > 0) begin
                out_ready = 1'b0;
            end
        end
        chk("done_seen", got_done, 1'b1);
    endtask

    logic [255:0] k1, nk;
    logic [127:0] v1, nv;

    initial begin
        rst = 1'b1; req_valid = 1'b0; key_in = '0; v_in = '0; reseed_counter_in = '0;
        additional_input = '0; num_blocks = '0; out_ready = 1'b1; aes_done = 1'b0; aes_ct = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_aes_start", aes_start, 1'b0);
        chk("rst_new_V", new_V, 128'd0);

        // basic generate
        run('0, '0, 32'd1, '0, 16'd2, 0);
        chk("b_status", got_st, 2'd0);
        chk("b_starts", n_starts, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("b_pt%0d", i), pt_at(i), 128'(i + 1));
        chk("b_blk0", dat_at(0), aes_f('0, 128'd1));
        chk("b_blk1", dat_at(1), aes_f('0, 128'd2));
        chk("b_last0", last_at(0), 1'b0);
        chk("b_last1", last_at(1), 1'b1);
        chk("b_new_key", new_key, {aes_f('0, 128'd3), aes_f('0, 128'd4)});
        chk("b_new_V", new_V, aes_f('0, 128'd5));
        chk("b_new_ctr", new_reseed_counter, 32'd2);

        // additional input
        k1 = {aes_f('0, 128'd1), aes_f('0, 128'd2)};
        v1 = aes_f('0, 128'd3) ^ 128'd1;
        nk = {aes_f(k1, v1 + 128'd2), aes_f(k1, v1 + 128'd3)};
        nv = aes_f(k1, v1 + 128'd4) ^ 128'd1;
        run('0, '0, 32'd7, 384'h1, 16'd1, 0);
        chk("a_starts", n_starts, 7);
        chk("a_pt0", pt_at(0), 128'd1);
        chk("a_pt2", pt_at(2), 128'd3);
        chk("a_gen_pt", pt_at(3), v1 + 128'd1);
        chk("a_blk", dat_at(0), aes_f(k1, v1 + 128'd1));
        chk("a_new_key", new_key, nk);
        chk("a_new_V", new_V, nv);
        chk("a_new_ctr", new_reseed_counter, 32'd8);

        // V wrap
        run('0, '1, 32'd3, '0, 16'd1, 0);
        chk("w_pt0", pt_at(0), 128'd0);
        chk("w_pt1", pt_at(1), 128'd1);
        chk("w_pt3", pt_at(3), 128'd3);
        chk("w_blk", dat_at(0), aes_f('0, 128'd0));
        chk("w_last", last_at(0), 1'b1);
        chk("w_new_V", new_V, aes_f('0, 128'd3));

        // errors: new_* must keep the V-wrap results
        run('0, '0, 32'd1048577, '0, 16'd1, 0);
        chk("e1_status", got_st, 2'd1);
        chk("e1_lat", got_cyc, 0);
        chk("e1_starts", n_starts, 0);
        chk("e1_new_V", new_V, aes_f('0, 128'd3));
        chk("e1_new_ctr", new_reseed_counter, 32'd4);
        run('0, '0, 32'd1, '0, 16'd0, 0);
        chk("e2_status", got_st, 2'd2);
        chk("e2_starts", n_starts, 0);
        run('0, '0, 32'd1, '0, 16'd4097, 0);
        chk("e3_status", got_st, 2'd2);
        chk("e3_starts", n_starts, 0);
        run('0, '0, 32'd1048576, '0, 16'd1, 0);
        chk("ilim_status", got_st, 2'd0);
        chk("ilim_new_ctr", new_reseed_counter, 32'd1048577);

        // backpressure
        run('0, '0, 32'd1, '0, 16'd3, 10);
        chk("bp_handshakes", q_dat.size(), 3);
        chk("bp_stable", stable_err, 0);
        chk("bp_stall_starts", stall_starts, 0);
        for (int i = 0; i < 3; i++) chk($sformatf("bp_blk%0d", i), dat_at(i), aes_f('0, 128'(i + 1)));
        chk("bp_last1", last_at(1), 1'b0);
        chk("bp_last2", last_at(2), 1'b1);

        // reset while GEN waits on aes_done; the late done must be ignored
        lat = 6;
        out_ready = 1'b1;
        @(negedge clk);
        key_in = '0; v_in = '0; reseed_counter_in = 32'd1; additional_input = '0; num_blocks = 16'd1;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 20 && n_starts == 0; i++) @(negedge clk);
        n_starts = 0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        begin
            int bad = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (out_valid || done || aes_start) bad++;
            end
            chk("mr_quiet", bad, 0);
        end
        chk("mr_req_ready", req_ready, 1'b1);
        chk("mr_new_V", new_V, 128'd0);
        chk("mr_status", status, 2'd0);
        lat = 3;
        run('0, '0, 32'd1, '0, 16'd2, 0);
        chk("mr_re_status", got_st, 2'd0);
        chk("mr_re_new_V", new_V, aes_f('0, 128'd5));

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/ctr_drbg_generate.md
Name: ctr_drbg_generate

Overview:
- Consumer side of the CTR_DRBG working state (AES-256, 128-bit V, no derivation function, SP 800-90A).
- Takes the Key, V and reseed_counter produced by instantiate or reseed, and streams NUM pseudorandom 128-bit blocks to a downstream consumer.
- Then runs the Update step and returns the new working state.
- Drives a shared external AES-256 encrypt core through a start/done handshake.

Parameters:
- RESEED_INTERVAL, 32'd1048576, maximum reseed_counter value accepted before a reseed is demanded.
- MAX_BLOCKS, 16'd4096, maximum 128-bit blocks per request.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  generate request
- req_ready  out  1  high only in IDLE
- key_in  in  256  working Key
- v_in  in  128  working V
- reseed_counter_in  in  32  current reseed counter
- additional_input  in  384  additional input; all-zero means none
- num_blocks  in  16  blocks requested
- aes_start  out  1  one-cycle start pulse to AES core
- aes_key  out  256  AES key
- aes_pt  out  128  AES plaintext
- aes_done  in  1  one-cycle pulse, aes_ct valid
- aes_ct  in  128  AES ciphertext
- out_valid  out  1  output block valid
- out_ready  in  1  consumer ready
- out_data  out  128  output block
- out_last  out  1  marks final block
- done  out  1  one-cycle completion pulse
- status  out  2  0 = OK, 1 = RESEED_REQUIRED, 2 = BAD_LENGTH; valid with done
- new_key  out  256  updated Key, valid with done status OK
- new_V  out  128  updated V
- new_reseed_counter  out  32  reseed_counter_in + 1

Behaviour:
- **Reset:** state IDLE; all outputs 0 except req_ready = 1 once reset deasserts. Internal Key, V, temp, counters cleared.
- **Reset mid-operation:** aborts immediately with no done pulse. Any aes_done arriving afterwards is ignored.
- **Request acceptance:** on req_valid & req_ready, capture all request inputs. Reject checks in this order:
  - reseed_counter_in > RESEED_INTERVAL → ERR with status 1.
  - num_blocks == 0 or > MAX_BLOCKS → ERR with status 2.
  - ERR: done = 1 for one cycle, new_* unchanged (hold previous values), back to IDLE. No AES activity.
- **States:** IDLE → ADD_UPD (only if additional_input != 0) → GEN → OUT → … → FIN_UPD → DONE → IDLE.
- **Update subroutine (ADD_UPD and FIN_UPD), 3 iterations:**
  - Each iteration: V = V + 1 mod 2^128, then pulse aes_start with aes_pt = V, aes_key = Key.
  - Wait for aes_done and store aes_ct into temp. Iteration 1 fills temp[383:256], 2 fills [255:128], 3 fills [127:0].
  - Then temp ^= additional_input; Key = temp[383:128]; V = temp[127:0].
  - FIN_UPD always uses the captured additional_input, zero or not.
- **GEN:**
  - V = V + 1 mod 2^128 (all-ones wraps to 0), then aes_start.
  - On aes_done: out_data = aes_ct, out_valid = 1, go to OUT.
- **OUT:**
  - Hold out_data/out_valid/out_last stable until out_ready.
  - On handshake, decrement remaining; go to GEN if remaining != 0, else FIN_UPD.
  - out_last = 1 on the final block only.
  - The next AES start is not issued until the current block is accepted, so there is no output buffer beyond one block.
- **AES handshake rules:**
  - aes_start is exactly one cycle.
  - aes_key/aes_pt are held stable from the start pulse until aes_done.
  - At most one outstanding AES operation.
  - aes_done outside a wait state is ignored.
- **DONE:** done = 1 for one cycle, status 0, new_key/new_V/new_reseed_counter registered. These hold until the next completion or reset.
- **Latency (AES core with latency L cycles, out_ready held high):**
  - ≈ 1 + (additional_input != 0 ? 3(L+1) : 0) + NUM·(L+2) + 3(L+1) + 1.
  - The bench checks ordering and counts, not exact totals.
- **new_reseed_counter:** 32-bit add; reseed_counter_in = 32'hFFFFFFFF cannot reach here because RESEED_INTERVAL is below it.
- req_valid while busy: ignored (req_ready = 0).

Test Plan:
- **Basic generate:**
  - Stimulus: Key = 0, V = 0, counter = 1, additional_input = 0, num_blocks = 2; bench AES model.
  - Required response: aes_pt sequence 1, 2 (GEN), then 3, 4, 5 (FIN_UPD). Out blocks = AES(0,1), AES(0,2), out_last on the 2nd. new_V = AES(0,5), new_reseed_counter = 2, status 0.
- **Additional input:**
  - Stimulus: additional_input = 384'h1, V = 0, num_blocks = 1.
  - Required response: ADD_UPD issues pt 1, 2, 3; Key' = AES(0,1)||AES(0,2); V' = AES(0,3)^1. GEN pt = V'+1. Final update XORs 384'h1 again.
- **V wrap:**
  - Stimulus: v_in = 128'hFFFF…FFFF, num_blocks = 1, additional_input = 0.
  - Required response: first aes_pt = 0, then FIN_UPD pts 1, 2, 3.
- **Errors:**
  - reseed_counter_in = RESEED_INTERVAL+1 → done with status 1 after one cycle, zero aes_start pulses.
  - num_blocks = 0 → status 2.
  - num_blocks = MAX_BLOCKS+1 → status 2.
- **Backpressure:**
  - Stimulus: num_blocks = 3, out_ready low for 10 cycles per block.
  - Required response: out_data stable while out_valid & !out_ready; no aes_start during stall; exactly 3 handshakes; out_last on the 3rd.
- **Reset mid-operation:**
  - Stimulus: assert rst while waiting on aes_done in GEN, then deliver aes_done.
  - Required response: all outputs 0, req_ready = 1 after release, no out_valid or done. A new request then completes normally.
